// File: rtl/map_read_arbiter.sv
//------------------------------------------------------------------------------
// map_read_arbiter: two-port arbiter for the single combinational map read port
// (A = tracer, high priority; B = overlay, starvation-protected).
// Option macro: MAP_ARB_ROUND_ROBIN_EN selects round-robin contention handling.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module map_read_arbiter #(
  parameter int BITS         = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_req,
  input  logic [3:0]      a_row,
  input  logic [3:0]      a_col,
  output logic            a_ack,
  output logic [BITS-1:0] a_val,
  input  logic            b_req,
  input  logic [3:0]      b_row,
  input  logic [3:0]      b_col,
  output logic            b_ack,
  output logic [BITS-1:0] b_val,
  output logic [3:0]      map_row,
  output logic [3:0]      map_col,
  input  logic [BITS-1:0] map_val
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;   // 1 = B owns the current transaction
  logic            a_ack_q, a_ack_d;
  logic            b_ack_q, b_ack_d;
  logic [BITS-1:0] a_val_q, a_val_d;
  logic [BITS-1:0] b_val_q, b_val_d;
  logic [3:0]      map_row_q, map_row_d;
  logic [3:0]      map_col_q, map_col_d;
  logic            grant_b;

`ifdef MAP_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;   // 1 = B granted last

  always_comb grant_b = b_req & (~a_req | ~last_grant_q);
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb grant_b = b_req & (~a_req | (starve_cnt_q >= LIMIT));
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    a_ack_d   = a_ack_q;
    b_ack_d   = b_ack_q;
    a_val_d   = a_val_q;
    b_val_d   = b_val_q;
    map_row_d = map_row_q;
    map_col_d = map_col_q;
`ifdef MAP_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          map_row_d = grant_b ? b_row : a_row;
          map_col_d = grant_b ? b_col : a_col;
          owner_d   = grant_b;
          state_d   = READ;
`ifdef MAP_ARB_ROUND_ROBIN_EN
          last_grant_d = grant_b;
`else
          // Only an A grant that actually made B wait counts toward starvation.
          starve_cnt_d = (grant_b || !b_req) ? 4'd0 : starve_cnt_q + 4'd1;
`endif
        end
      end
      READ: begin
        if (owner_q) begin
          b_val_d = map_val;
          b_ack_d = 1'b1;
        end else begin
          a_val_d = map_val;
          a_ack_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_val_q   <= '0;
      b_val_q   <= '0;
      map_row_q <= 4'd0;
      map_col_q <= 4'd0;
`ifdef MAP_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_val_q   <= a_val_d;
      b_val_q   <= b_val_d;
      map_row_q <= map_row_d;
      map_col_q <= map_col_d;
`ifdef MAP_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_val   = a_val_q;
  assign b_val   = b_val_q;
  assign map_row = map_row_q;
  assign map_col = map_col_q;

endmodule

`default_nettype wire

// File: tb/tb_map_read_arbiter.sv
//------------------------------------------------------------------------------
// tb_map_read_arbiter: vector table plus hand sequences, scoreboard of expected
// winners/values checked at each ack pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_map_read_arbiter;
  localparam int BITS = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            a_req = 1'b0, b_req = 1'b0;
  logic [3:0]      a_row = '0, a_col = '0, b_row = '0, b_col = '0;
  logic            a_ack, b_ack;
  logic [BITS-1:0] a_val, b_val;
  logic [3:0]      map_row, map_col;
  logic [BITS-1:0] map_val;

  logic [BITS-1:0] mem [16][16];
  assign map_val = mem[map_row][map_col];

  always #5 clk = ~clk;

  map_read_arbiter #(.BITS(BITS), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_row(a_row), .a_col(a_col), .a_ack(a_ack), .a_val(a_val),
    .b_req(b_req), .b_row(b_row), .b_col(b_col), .b_ack(b_ack), .b_val(b_val),
    .map_row(map_row), .map_col(map_col), .map_val(map_val)
  );

  typedef struct {
    logic       a_req, b_req;
    logic [3:0] ar, ac, br, bc;
    logic       exp_b_fixed, exp_b_rr;
  } vec_t;

  typedef struct {
    logic            is_b;
    logic [BITS-1:0] val;
  } exp_t;

  exp_t            sb[$];
  vec_t            vecs[12];
  int              errors = 0;
  int              checks = 0;
  logic [BITS-1:0] exp_a_val = '0, exp_b_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ra, input logic rb, input logic [3:0] ar,
                              input logic [3:0] ac, input logic [3:0] br, input logic [3:0] bc,
                              input logic ef, input logic er);
    vec_t v;
    v.a_req = ra; v.b_req = rb; v.ar = ar; v.ac = ac; v.br = br; v.bc = bc;
    v.exp_b_fixed = ef; v.exp_b_rr = er;
    return v;
  endfunction

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_a_val = '0; exp_b_val = '0;
    sb.delete();
  endtask

  task automatic wait_ack(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        n = i; ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
    end
  endtask

  // Called at a negedge where an ack is visible.
  task automatic check_ack();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: got ack a=%0b b=%0b expected none", a_ack, b_ack);
      return;
    end
    e = sb.pop_front();
    chk("ack_sel", {30'd0, a_ack, b_ack}, e.is_b ? 32'd1 : 32'd2);
    if (e.is_b) begin
      chk("b_val", b_val, e.val);
      chk("a_val_hold", a_val, exp_a_val);
      exp_b_val = e.val;
    end else begin
      chk("a_val", a_val, e.val);
      chk("b_val_hold", b_val, exp_b_val);
      exp_a_val = e.val;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic eb;
    int   n;
    bit   ok;
    exp_t e;
`ifdef MAP_ARB_ROUND_ROBIN_EN
    eb = v.exp_b_rr;
`else
    eb = v.exp_b_fixed;
`endif
    @(negedge clk);
    a_req = v.a_req; b_req = v.b_req;
    a_row = v.ar; a_col = v.ac; b_row = v.br; b_col = v.bc;
    e.is_b = eb;
    e.val  = eb ? mem[v.br][v.bc] : mem[v.ar][v.ac];
    sb.push_back(e);
    @(posedge clk); #1;
    chk("map_row", map_row, eb ? v.br : v.ar);
    chk("map_col", map_col, eb ? v.bc : v.ac);
    wait_ack(n, ok);
    if (ok) begin
      chk("latency", n, 1);
      check_ack();
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    chk("ack_low", {a_ack, b_ack}, 0);
  endtask

  initial begin
    int n, acks, backs;
    bit ok;
    exp_t e;
    logic exp_b;

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = BITS'($urandom_range(0, 3));
    mem[3][5] = 2'd2; mem[0][0] = 2'd1; mem[1][2] = 2'd3;
    mem[4][7] = 2'd1; mem[5][9] = 2'd2; mem[9][14] = 2'd3; mem[15][15] = 2'd1;

    //             a  b  ar ac  br  bc  fixed rr
    vecs[0]  = mk(1, 0, 3, 5,  9, 14, 0, 0);
    vecs[1]  = mk(0, 1, 3, 5,  0, 0,  1, 1);
    vecs[2]  = mk(1, 1, 1, 2,  4, 7,  0, 0);
    vecs[3]  = mk(1, 1, 15, 15, 9, 14, 0, 1);
    vecs[4]  = mk(1, 1, 3, 5,  1, 2,  0, 0);
    vecs[5]  = mk(1, 1, 5, 9,  4, 7,  0, 1);
    vecs[6]  = mk(1, 1, 3, 5,  9, 14, 1, 0);
    vecs[7]  = mk(1, 1, 1, 2,  15, 15, 0, 1);
    vecs[8]  = mk(1, 0, 5, 9,  3, 5,  0, 0);
    vecs[9]  = mk(1, 1, 4, 7,  1, 2,  0, 1);
    vecs[10] = mk(0, 1, 3, 5,  5, 9,  1, 1);
    vecs[11] = mk(1, 1, 9, 14, 3, 5,  0, 0);

    #2 do_reset();
    #1;
    chk("rst_a_ack", a_ack, 0);   chk("rst_b_ack", b_ack, 0);
    chk("rst_a_val", a_val, 0);   chk("rst_b_val", b_val, 0);
    chk("rst_map_row", map_row, 0); chk("rst_map_col", map_col, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Continuous contention from a fresh reset.
    do_reset();
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1;
    a_row = 4'd1; a_col = 4'd2; b_row = 4'd4; b_col = 4'd7;
    for (int k = 0; k < 10; k++) begin
`ifdef MAP_ARB_ROUND_ROBIN_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = (k % 5) == 4;
`endif
      e.is_b = exp_b;
      e.val  = exp_b ? mem[4][7] : mem[1][2];
      sb.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      wait_ack(n, ok);
      if (!ok) break;
      chk("contention_gap", n, (k == 0) ? 1 : 2);
      check_ack();
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();

    // Request held across several acks: each IDLE re-grants it.
    @(negedge clk);
    a_req = 1'b1; a_row = 4'd3; a_col = 4'd5;
    repeat (3) begin
      e.is_b = 1'b0; e.val = mem[3][5];
      sb.push_back(e);
    end
    acks = 0; backs = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (a_ack) begin
        acks++;
        check_ack();
      end
      if (b_ack) backs++;
    end
    a_req = 1'b0;
    chk("held_a_acks", acks, 3);
    chk("held_b_acks", backs, 0);
    repeat (2) @(posedge clk);
    #1 chk("held_drained", {a_ack, b_ack}, 0);

    // Asynchronous reset while a read is in flight.
    @(negedge clk);
    a_req = 1'b1; a_row = 4'd5; a_col = 4'd9;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_a_ack", a_ack, 0);   chk("mid_rst_b_ack", b_ack, 0);
    chk("mid_rst_a_val", a_val, 0);   chk("mid_rst_b_val", b_val, 0);
    chk("mid_rst_map_row", map_row, 0); chk("mid_rst_map_col", map_col, 0);
    a_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    reset_n = 1'b1;
    exp_a_val = '0; exp_b_val = '0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    chk("mid_rst_no_ack", acks, 0);
    run_vec(mk(1, 0, 5, 9, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
